// File: rtl/button_debounce_ctrl.sv
// Push-button front end: two-flop synchroniser, per-button debounce,
// sticky rise/fall event latches and a picosoc memory-mapped slave.
//
// Ports:
//   clk, resetn      clock, asynchronous active-low reset
//   addr/wdata/wstrb picosoc bus request (addr[3:2] selects register)
//   valid/ready      request strobe / one-cycle acknowledge
//   rdata            read data, zero outside the acknowledge cycle
//   btn_raw          raw asynchronous button pins, active-high
//   btn_clean        debounced levels for the PL peripheral
//   irq              level interrupt, OR of enabled rise events
//
// Registers (word offsets):
//   0x0 STATUS  RO    debounced levels
//   0x4 RISE    RW1C  sticky rise events
//   0x8 FALL    RW1C  sticky fall events
//   0xC IRQ_EN  RW    per-button rise interrupt enable

module button_debounce_ctrl #(
   parameter int NBTN            = 3,
   parameter int DEBOUNCE_CYCLES = 12000,
   parameter int CTR_W           = 14
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic [15:0]     addr,
   input  logic [31:0]     wdata,
   input  logic [3:0]      wstrb,
   output logic [31:0]     rdata,
   input  logic            valid,
   output logic            ready,
   input  logic [NBTN-1:0] btn_raw,
   output logic [NBTN-1:0] btn_clean,
   output logic            irq
);

   localparam logic [CTR_W-1:0] CNT_MAX =
      CTR_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_RISE   = 2'd1;
   localparam logic [1:0] A_FALL   = 2'd2;
   localparam logic [1:0] A_IRQEN  = 2'd3;

   // ------------------------------------------------------------
   // Synchroniser
   // ------------------------------------------------------------
   logic [NBTN-1:0] sync1_q;
   logic [NBTN-1:0] sync2_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   // ------------------------------------------------------------
   // Debounce
   // ------------------------------------------------------------
   logic [NBTN-1:0]  clean_q;
   logic [NBTN-1:0]  clean_d;
   logic [CTR_W-1:0] cnt_q [NBTN];
   logic [CTR_W-1:0] cnt_d [NBTN];
   logic [NBTN-1:0]  rise_set;
   logic [NBTN-1:0]  fall_set;

   // The counter only runs while the synchronised level disagrees
   // with the accepted level; any agreement restarts it, so a level
   // must be held for DEBOUNCE_CYCLES consecutive samples to win.
   // The >= comparison keeps the counter from ever wrapping.
   always_comb begin
      clean_d  = clean_q;
      rise_set = '0;
      fall_set = '0;
      for (int i = 0; i < NBTN; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != clean_q[i]) begin
            if (cnt_q[i] >= CNT_MAX) begin
               clean_d[i]  = sync2_q[i];
               rise_set[i] = sync2_q[i];
               fall_set[i] = ~sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         clean_q <= '0;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         clean_q <= clean_d;
         for (int i = 0; i < NBTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // ------------------------------------------------------------
   // Bus slave
   // ------------------------------------------------------------
   logic            ready_q;
   logic            ready_d;
   logic [31:0]     rdata_q;
   logic [31:0]     rdata_d;
   logic [NBTN-1:0] rise_q;
   logic [NBTN-1:0] rise_d;
   logic [NBTN-1:0] fall_q;
   logic [NBTN-1:0] fall_d;
   logic [NBTN-1:0] irq_en_q;
   logic [NBTN-1:0] irq_en_d;

   logic            acc;
   logic            wr;
   logic [1:0]      sel;
   logic [NBTN-1:0] wbits;
   logic [NBTN-1:0] rsel;
   logic [NBTN-1:0] rise_clr;
   logic [NBTN-1:0] fall_clr;

   // An access is taken only while ready is low, which spaces
   // acknowledges at least two cycles apart under held valid.
   assign acc   = valid && !ready_q;
   assign wr    = acc && wstrb[0];
   assign sel   = addr[3:2];
   assign wbits = wdata[NBTN-1:0];

   always_comb begin
      rsel = '0;
      unique case (sel)
         A_STATUS: rsel = clean_q;
         A_RISE:   rsel = rise_q;
         A_FALL:   rsel = fall_q;
         A_IRQEN:  rsel = irq_en_q;
      endcase
   end

   always_comb begin
      rise_clr = '0;
      fall_clr = '0;
      irq_en_d = irq_en_q;
      if (wr) begin
         if (sel == A_RISE)  rise_clr = wbits;
         if (sel == A_FALL)  fall_clr = wbits;
         if (sel == A_IRQEN) irq_en_d = wbits;
      end
   end

   // A new event in the same cycle as its clear keeps the bit set.
   assign rise_d = (rise_q & ~rise_clr) | rise_set;
   assign fall_d = (fall_q & ~fall_clr) | fall_set;

   // Read data is captured from the pre-write register values.
   always_comb begin
      ready_d = acc;
      rdata_d = '0;
      if (acc) begin
         rdata_d = {{(32-NBTN){1'b0}}, rsel};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ready_q  <= 1'b0;
         rdata_q  <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         irq_en_q <= '0;
      end else begin
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         irq_en_q <= irq_en_d;
      end
   end

   logic unused_bits;
   assign unused_bits = ^{addr[15:4], addr[1:0],
                          wdata[31:NBTN], wstrb[3:1]};

   assign ready     = ready_q;
   assign rdata     = rdata_q;
   assign btn_clean = clean_q;
   assign irq       = |(rise_q & irq_en_q);

endmodule

// File: tb/tb_button_debounce_ctrl.sv
// Self-checking bench for button_debounce_ctrl (DEBOUNCE_CYCLES=4).
// Bus reads are scoreboarded; button timing is checked inline.

module tb_button_debounce_ctrl;

   localparam int NBTN = 3;

   logic            clk = 1'b0;
   logic            resetn;
   logic [15:0]     addr;
   logic [31:0]     wdata;
   logic [3:0]      wstrb;
   logic [31:0]     rdata;
   logic            valid;
   logic            ready;
   logic [NBTN-1:0] btn_raw;
   logic [NBTN-1:0] btn_clean;
   logic            irq;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_q[$];

   typedef struct {
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic [31:0] e;
      string       n;
   } vec_t;

   vec_t tbl [0:18];

   button_debounce_ctrl #(
      .NBTN(NBTN),
      .DEBOUNCE_CYCLES(4),
      .CTR_W(3)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .addr(addr),
      .wdata(wdata),
      .wstrb(wstrb),
      .rdata(rdata),
      .valid(valid),
      .ready(ready),
      .btn_raw(btn_raw),
      .btn_clean(btn_clean),
      .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One access plus an idle cycle so the next one is accepted.
   task automatic bus(input logic [15:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input logic [31:0] e);
      addr  = a;
      wdata = d;
      wstrb = s;
      valid = 1'b1;
      exp_q.push_back(e);
      tick(1);
      valid = 1'b0;
      wstrb = 4'b0;
      tick(1);
   endtask

   // Scoreboard: pop on every acknowledge, rdata must be 0 otherwise.
   always @(negedge clk) begin
      if (ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", 32'd1, 32'd0);
         end else begin
            chk("rdata", rdata, exp_q.pop_front());
         end
      end else begin
         chk("rdata_idle", rdata, 32'd0);
      end
   end

   initial begin
      tbl[0]  = '{16'h0000, 32'h0, 4'h0, 32'h0, "st"};
      tbl[1]  = '{16'h0004, 32'h0, 4'h0, 32'h7, "rise"};
      tbl[2]  = '{16'h0004, 32'h1, 4'h1, 32'h7, "rise_w"};
      tbl[3]  = '{16'h1004, 32'h0, 4'h0, 32'h6, "rise_hi"};
      tbl[4]  = '{16'h0004, 32'h6, 4'hF, 32'h6, "rise_w2"};
      tbl[5]  = '{16'h0004, 32'h0, 4'h0, 32'h0, "rise_0"};
      tbl[6]  = '{16'h0008, 32'h5, 4'h1, 32'h7, "fall_w"};
      tbl[7]  = '{16'h0008, 32'h0, 4'h0, 32'h2, "fall"};
      tbl[8]  = '{16'h0008, 32'hFFFFFFFF, 4'h1, 32'h2, "fall_w2"};
      tbl[9]  = '{16'h0008, 32'h0, 4'h0, 32'h0, "fall_0"};
      tbl[10] = '{16'h000C, 32'h5, 4'h1, 32'h0, "en_w"};
      tbl[11] = '{16'h000C, 32'h0, 4'h0, 32'h5, "en"};
      tbl[12] = '{16'h000C, 32'h0, 4'h2, 32'h5, "en_w_b1"};
      tbl[13] = '{16'h000C, 32'h0, 4'h0, 32'h5, "en_keep"};
      tbl[14] = '{16'h000C, 32'hFFFFFFF8, 4'h1, 32'h5, "en_w0"};
      tbl[15] = '{16'h000C, 32'h0, 4'h0, 32'h0, "en_0"};
      tbl[16] = '{16'h0000, 32'h7, 4'hF, 32'h0, "st_w"};
      tbl[17] = '{16'h0000, 32'h0, 4'h0, 32'h0, "st_2"};
      tbl[18] = '{16'h0003, 32'h0, 4'h0, 32'h0, "st_b"};

      resetn  = 1'b0;
      addr    = '0;
      wdata   = '0;
      wstrb   = '0;
      valid   = 1'b0;
      btn_raw = 3'b111;

      // Reset state with buttons pressed.
      tick(3);
      chk("rst_clean", 32'(btn_clean), 32'h0);
      chk("rst_ready", 32'(ready), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);

      // Release: first sample edge is the next edge.
      resetn = 1'b1;
      tick(5);
      chk("rel_clean_e4", 32'(btn_clean), 32'h0);
      tick(1);
      chk("rel_clean_e5", 32'(btn_clean), 32'h7);

      btn_raw = 3'b000;
      tick(8);
      chk("all_fall", 32'(btn_clean), 32'h0);

      // Register map vectors (rise=7, fall=7, en=0).
      for (int i = 0; i < 19; i++) begin
         bus(tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].e);
      end
      chk("irq_tbl", 32'(irq), 32'h0);

      // Glitch of 3 cycles on button 1 is rejected.
      btn_raw = 3'b010;
      tick(3);
      btn_raw = 3'b000;
      tick(6);
      chk("glitch_clean", 32'(btn_clean), 32'h0);
      bus(16'h4, 32'h0, 4'h0, 32'h0);

      // Held press on button 1 accepted after 5 edges.
      btn_raw = 3'b010;
      tick(5);
      chk("hold_e4", 32'(btn_clean), 32'h0);
      tick(1);
      chk("hold_e5", 32'(btn_clean), 32'h2);
      bus(16'h4, 32'h0, 4'h0, 32'h2);
      bus(16'h4, 32'h2, 4'h1, 32'h2);

      // Bounce on button 0.
      begin
         logic [8:0] seq;
         seq = 9'b111101101;
         for (int k = 0; k < 9; k++) begin
            btn_raw[0] = seq[k];
            tick(1);
            chk("bounce_hold", 32'(btn_clean), 32'h2);
         end
      end
      tick(1);
      chk("bounce_e9", 32'(btn_clean), 32'h2);
      tick(1);
      chk("bounce_e10", 32'(btn_clean), 32'h3);
      bus(16'h4, 32'h0, 4'h0, 32'h1);
      bus(16'h8, 32'h0, 4'h0, 32'h0);
      bus(16'h4, 32'h1, 4'h1, 32'h1);

      // W1C race: clear lands on the edge the rise is accepted.
      btn_raw = 3'b010;
      tick(8);
      bus(16'h8, 32'h1, 4'h1, 32'h1);
      btn_raw = 3'b011;
      tick(5);
      chk("race_pre", 32'(btn_clean), 32'h2);
      bus(16'h4, 32'h1, 4'h1, 32'h0);
      chk("race_post", 32'(btn_clean), 32'h3);
      bus(16'h4, 32'h0, 4'h0, 32'h1);
      bus(16'h4, 32'h1, 4'h1, 32'h1);
      bus(16'h4, 32'h0, 4'h0, 32'h0);

      // Interrupt enable on button 2 only.
      bus(16'hC, 32'h4, 4'h1, 32'h0);
      btn_raw = 3'b010;
      tick(8);
      btn_raw = 3'b011;
      tick(8);
      chk("irq_b0", 32'(irq), 32'h0);
      btn_raw = 3'b111;
      tick(5);
      chk("irq_b2_e4", 32'(irq), 32'h0);
      tick(1);
      chk("irq_b2_e5", 32'(irq), 32'h1);
      addr  = 16'h4;
      wdata = 32'h4;
      wstrb = 4'h1;
      valid = 1'b1;
      exp_q.push_back(32'h5);
      tick(1);
      valid = 1'b0;
      wstrb = 4'h0;
      chk("irq_clr", 32'(irq), 32'h0);
      tick(1);

      // Valid held 4 cycles per offset: acks on cycles 1 and 3.
      begin
         logic [31:0] held_exp [4];
         held_exp = '{32'h7, 32'h1, 32'h1, 32'h4};
         for (int r = 0; r < 4; r++) begin
            addr  = 16'(r * 4);
            wstrb = 4'h0;
            valid = 1'b1;
            exp_q.push_back(held_exp[r]);
            exp_q.push_back(held_exp[r]);
            for (int c = 0; c < 4; c++) begin
               tick(1);
               chk("held_ready", 32'(ready),
                   (c % 2 == 0) ? 32'h1 : 32'h0);
            end
            valid = 1'b0;
            tick(1);
         end
      end

      // STATUS writes ignored while buttons are held.
      bus(16'h0, 32'h0, 4'hF, 32'h7);
      bus(16'h0, 32'h0, 4'h0, 32'h7);

      tick(2);
      chk("pending", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
